// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken-branch, slow-memory
// and invalid-opcode handling, plus saturating stall/flush performance counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned DRAIN_DEPTH = 3,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             id_inv_op,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_we,
    output logic             pc_sel_branch,
    output logic             if_id_we,
    output logic             if_id_flush,
    output logic             id_ex_we,
    output logic             id_ex_bubble,
    output logic             ex_mem_we,
    output logic             mem_wb_bubble,
    output logic             halted,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [1:0] S_RUN      = 2'd0;
    localparam logic [1:0] S_MEM_WAIT = 2'd1;
    localparam logic [1:0] S_DRAIN    = 2'd2;
    localparam logic [1:0] S_HALT     = 2'd3;

    localparam int unsigned WAIT_W  = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam int unsigned DRAIN_W = (DRAIN_DEPTH > 1) ? $clog2(DRAIN_DEPTH + 1) : 1;

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [WAIT_W-1:0]  wait_cnt_nxt;
    logic [DRAIN_W-1:0] drain_cnt;
    logic [DRAIN_W-1:0] drain_cnt_nxt;
    logic               timeout;
    logic               flush_inc;
    logic               stall_inc;
    logic               freeze;
    logic               load_use;

    assign freeze   = mem_req && !mem_ready;
    assign load_use = ex_memread && (ex_rd != 5'd0) &&
                      (((ex_rd == id_rs1) && id_use_rs1) || ((ex_rd == id_rs2) && id_use_rs2));

    // Next state and combinational pipeline controls; MEM_WAIT acts as RUN once unfrozen.
    always_comb begin
        state_nxt     = state;
        wait_cnt_nxt  = wait_cnt;
        drain_cnt_nxt = drain_cnt;
        timeout       = 1'b0;
        flush_inc     = 1'b0;
        pc_we         = 1'b1;
        pc_sel_branch = 1'b0;
        if_id_we      = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_we      = 1'b1;
        id_ex_bubble  = 1'b0;
        ex_mem_we     = 1'b1;
        mem_wb_bubble = 1'b0;

        if (rst) begin
            pc_we     = 1'b0;
            if_id_we  = 1'b0;
            id_ex_we  = 1'b0;
            ex_mem_we = 1'b0;
        end else if (state == S_HALT) begin
            pc_we     = 1'b0;
            if_id_we  = 1'b0;
            id_ex_we  = 1'b0;
            ex_mem_we = 1'b0;
        end else if (freeze) begin
            pc_we         = 1'b0;
            if_id_we      = 1'b0;
            id_ex_we      = 1'b0;
            ex_mem_we     = 1'b0;
            mem_wb_bubble = 1'b1;
            wait_cnt_nxt  = wait_cnt + WAIT_W'(1);
            if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
                state_nxt = S_HALT;
                timeout   = 1'b1;
            end else if (state == S_RUN) begin
                state_nxt = S_MEM_WAIT;
            end
        end else begin
            wait_cnt_nxt = '0;
            if (state == S_DRAIN) begin
                pc_we        = 1'b0;
                if_id_we     = 1'b0;
                id_ex_bubble = 1'b1;
                if (drain_cnt <= DRAIN_W'(1)) begin
                    drain_cnt_nxt = '0;
                    state_nxt     = S_HALT;
                end else begin
                    drain_cnt_nxt = drain_cnt - DRAIN_W'(1);
                end
            end else begin
                state_nxt = S_RUN;
                if (ex_branch_taken) begin
                    pc_sel_branch = 1'b1;
                    if_id_flush   = 1'b1;
                    id_ex_bubble  = 1'b1;
                    flush_inc     = 1'b1;
                end else if (id_inv_op) begin
                    pc_we         = 1'b0;
                    if_id_we      = 1'b0;
                    id_ex_bubble  = 1'b1;
                    drain_cnt_nxt = DRAIN_W'(DRAIN_DEPTH);
                    state_nxt     = S_DRAIN;
                end else if (load_use) begin
                    pc_we        = 1'b0;
                    if_id_we     = 1'b0;
                    id_ex_bubble = 1'b1;
                end
            end
        end
    end

    assign stall_inc = (state != S_HALT) && !pc_we;

    // State, status flags and saturating performance counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_RUN;
            wait_cnt     <= '0;
            drain_cnt    <= '0;
            halted       <= 1'b0;
            mem_err      <= 1'b0;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_cnt_nxt;
            drain_cnt <= drain_cnt_nxt;
            halted    <= (state_nxt == S_HALT);
            mem_err   <= mem_err || timeout;
            if (stall_inc && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (flush_inc && (flush_count != '1)) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized and directed bench for pipeline_hazard_ctrl against an integer-level
// reference model of the hazard rules.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned MEM_TIMEOUT = 8;
    localparam int unsigned DRAIN_DEPTH = 3;
    localparam int unsigned CNT_W       = 6;
    localparam int          CNT_MAX     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic             id_inv_op;
    logic             ex_memread;
    logic [4:0]       ex_rd;
    logic             ex_branch_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             pc_we;
    logic             pc_sel_branch;
    logic             if_id_we;
    logic             if_id_flush;
    logic             id_ex_we;
    logic             id_ex_bubble;
    logic             ex_mem_we;
    logic             mem_wb_bubble;
    logic             halted;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    pipeline_hazard_ctrl #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .DRAIN_DEPTH(DRAIN_DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_use_rs1     (id_use_rs1),
        .id_use_rs2     (id_use_rs2),
        .id_inv_op      (id_inv_op),
        .ex_memread     (ex_memread),
        .ex_rd          (ex_rd),
        .ex_branch_taken(ex_branch_taken),
        .mem_req        (mem_req),
        .mem_ready      (mem_ready),
        .pc_we          (pc_we),
        .pc_sel_branch  (pc_sel_branch),
        .if_id_we       (if_id_we),
        .if_id_flush    (if_id_flush),
        .id_ex_we       (id_ex_we),
        .id_ex_bubble   (id_ex_bubble),
        .ex_mem_we      (ex_mem_we),
        .mem_wb_bubble  (mem_wb_bubble),
        .halted         (halted),
        .mem_err        (mem_err),
        .stall_cycles   (stall_cycles),
        .flush_count    (flush_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: mode 0 = flowing (covers memory waits), 1 = draining, 2 = stopped.
    int   m_mode;
    int   m_wait;
    int   m_drain;
    int   m_stall;
    int   m_flush;
    bit   m_err;
    int   n_mode;
    int   n_wait;
    int   n_drain;
    bit   n_errflag;
    bit   e_stall;
    bit   e_flush;
    logic [7:0] e_vec;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        id_inv_op = 1'b0; ex_memread = 1'b0; ex_rd = '0; ex_branch_taken = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic rand_inputs();
        id_rs1          = 5'($urandom_range(0, 7));
        id_rs2          = 5'($urandom_range(0, 7));
        ex_rd           = 5'($urandom_range(0, 7));
        id_use_rs1      = 1'($urandom_range(0, 1));
        id_use_rs2      = 1'($urandom_range(0, 1));
        ex_memread      = ($urandom_range(0, 99) < 40);
        ex_branch_taken = ($urandom_range(0, 99) < 10);
        id_inv_op       = ($urandom_range(0, 99) < 3);
        mem_req         = ($urandom_range(0, 99) < 30);
        mem_ready       = ($urandom_range(0, 99) < 60);
    endtask

    // Expected controls for the current inputs, plus the model's next values.
    task automatic model_eval();
        bit frz;
        bit hit;
        frz = mem_req && !mem_ready;
        hit = ex_memread && (ex_rd != 0) &&
              ((ex_rd == id_rs1 && id_use_rs1) || (ex_rd == id_rs2 && id_use_rs2));
        // bit order: pc_we pc_sel if_id_we if_id_flush id_ex_we id_ex_bubble ex_mem_we mem_wb_bubble
        e_vec     = 8'b1010_1010;
        n_mode    = m_mode;
        n_wait    = m_wait;
        n_drain   = m_drain;
        n_errflag = m_err;
        e_flush   = 1'b0;
        if (m_mode == 2) begin
            e_vec = 8'b0000_0000;
        end else if (frz) begin
            e_vec  = 8'b0000_0001;
            n_wait = m_wait + 1;
            if (n_wait >= int'(MEM_TIMEOUT)) begin
                n_mode    = 2;
                n_errflag = 1'b1;
            end
        end else begin
            n_wait = 0;
            if (m_mode == 1) begin
                e_vec   = 8'b0000_1110;
                n_drain = m_drain - 1;
                if (n_drain <= 0) n_mode = 2;
            end else if (ex_branch_taken) begin
                e_vec   = 8'b1111_1110;
                e_flush = 1'b1;
            end else if (id_inv_op) begin
                e_vec   = 8'b0000_1110;
                n_mode  = 1;
                n_drain = int'(DRAIN_DEPTH);
            end else if (hit) begin
                e_vec = 8'b0000_1110;
            end
        end
        e_stall = (m_mode != 2) && !e_vec[7];
    endtask

    task automatic model_commit();
        m_mode  = n_mode;
        m_wait  = n_wait;
        m_drain = n_drain;
        m_err   = n_errflag;
        if (e_stall && m_stall < CNT_MAX) m_stall++;
        if (e_flush && m_flush < CNT_MAX) m_flush++;
    endtask

    task automatic model_reset();
        m_mode = 0; m_wait = 0; m_drain = 0; m_err = 1'b0; m_stall = 0; m_flush = 0;
    endtask

    // Entered and left at posedge+1; checks at the falling edge, model advances at the rising edge.
    task automatic run_cycle();
        @(negedge clk);
        model_eval();
        check("ctl", 64'({pc_we, pc_sel_branch, if_id_we, if_id_flush,
                          id_ex_we, id_ex_bubble, ex_mem_we, mem_wb_bubble}), 64'(e_vec));
        check("halted", 64'(halted), 64'(m_mode == 2));
        check("mem_err", 64'(mem_err), 64'(m_err));
        check("stall_cycles", 64'(stall_cycles), 64'(m_stall));
        check("flush_count", 64'(flush_count), 64'(m_flush));
        @(posedge clk);
        #1;
        model_commit();
    endtask

    // Asynchronous reset asserted mid-cycle with current inputs left applied.
    task automatic do_reset();
        rst = 1'b1;
        #2;
        check("rst_ctl", 64'({pc_we, pc_sel_branch, if_id_we, if_id_flush,
                              id_ex_we, id_ex_bubble, ex_mem_we, mem_wb_bubble}), 64'(0));
        check("rst_halted", 64'(halted), 64'(0));
        check("rst_mem_err", 64'(mem_err), 64'(0));
        check("rst_stall", 64'(stall_cycles), 64'(0));
        check("rst_flush", 64'(flush_count), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_inputs();
        model_reset();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        clear_inputs();
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();
        run_cycle();

        // load-use on rs1, then the same pattern with x0 as destination
        ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
        run_cycle();
        clear_inputs();
        run_cycle();
        ex_memread = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
        run_cycle();
        clear_inputs();

        // taken branch outranks invalid opcode and load-use
        ex_branch_taken = 1'b1; id_inv_op = 1'b1;
        ex_memread = 1'b1; ex_rd = 5'd3; id_rs2 = 5'd3; id_use_rs2 = 1'b1;
        run_cycle();
        clear_inputs();
        run_cycle();

        // four-cycle memory freeze
        mem_req = 1'b1; mem_ready = 1'b0;
        repeat (4) run_cycle();
        mem_ready = 1'b1;
        run_cycle();
        clear_inputs();
        run_cycle();

        // branch held across a freeze applies on the first free cycle
        mem_req = 1'b1; mem_ready = 1'b0; ex_branch_taken = 1'b1;
        repeat (2) run_cycle();
        mem_ready = 1'b1;
        run_cycle();
        clear_inputs();
        run_cycle();

        // memory timeout
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        n = 0;
        do begin
            run_cycle();
            n++;
        end while (!halted && n < 40);
        check("timeout_latency", 64'(n), 64'(MEM_TIMEOUT));
        clear_inputs();
        repeat (3) run_cycle();

        // invalid opcode drain, undisturbed
        do_reset();
        id_inv_op = 1'b1;
        run_cycle();
        clear_inputs();
        n = 1;
        while (!halted && n < 40) begin
            run_cycle();
            n++;
        end
        check("drain_latency", 64'(n), 64'(DRAIN_DEPTH + 1));
        repeat (2) run_cycle();

        // invalid opcode drain with a two-cycle freeze inside
        do_reset();
        id_inv_op = 1'b1;
        run_cycle();
        clear_inputs();
        run_cycle();
        mem_req = 1'b1; mem_ready = 1'b0;
        repeat (2) run_cycle();
        clear_inputs();
        n = 4;
        while (!halted && n < 40) begin
            run_cycle();
            n++;
        end
        check("drain_freeze_latency", 64'(n), 64'(DRAIN_DEPTH + 3));

        // reset in the middle of a memory wait
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        repeat (3) run_cycle();
        do_reset();
        repeat (2) run_cycle();

        // counter saturation
        ex_memread = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
        repeat (CNT_MAX + 6) run_cycle();
        clear_inputs();
        ex_branch_taken = 1'b1;
        repeat (CNT_MAX + 6) run_cycle();
        clear_inputs();
        run_cycle();

        // randomized traffic with resets to escape HALT
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ((m_mode == 2 && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0) begin
                rand_inputs();
                do_reset();
            end else begin
                rand_inputs();
                run_cycle();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage RV64 pipeline (IF, ID, EX, MEM, WB). It watches the decode fields, the ID/EX control bits and the data-memory handshake. From these it drives the PC and stage-register write enables and bubble/flush controls for load-use hazards, taken branches, slow memory and invalid opcodes. It also keeps saturating stall and flush performance counters.

## Interface
- MEM_TIMEOUT, 255: max consecutive cycles of unready memory before a fatal error.
- DRAIN_DEPTH, 3: bubble cycles needed to retire EX/MEM/WB before halting.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- id_rs1, id_rs2  in  5  source registers of the instruction in ID
- id_use_rs1, id_use_rs2  in  1  ID instruction actually reads that source
- id_inv_op  in  1  invalid opcode flag from the control unit, ID stage
- ex_memread  in  1  memread bit out of ID/EX
- ex_rd  in  5  write_reg out of ID/EX
- ex_branch_taken  in  1  branch resolved taken in EX
- mem_req  in  1  MEM stage issues a data-memory access
- mem_ready  in  1  data memory completes the access this cycle
- pc_we  out  1  PC register write enable
- pc_sel_branch  out  1  PC loads the branch target (valid with pc_we)
- if_id_we  out  1  IF/ID write enable
- if_id_flush  out  1  IF/ID loads a NOP
- id_ex_we  out  1  ID/EX write enable
- id_ex_bubble  out  1  ID/EX loads all-zero control bits
- ex_mem_we  out  1  EX/MEM write enable
- mem_wb_bubble  out  1  MEM/WB loads zero control bits
- halted  out  1  pipeline stopped; cleared only by rst
- mem_err  out  1  memory timeout occurred, sticky
- stall_cycles  out  CNT_W  cycles with pc_we=0 outside HALT, saturating
- flush_count  out  CNT_W  taken-branch flushes, saturating

## Operation
- States: RUN, MEM_WAIT, DRAIN, HALT. Reset state is RUN.
- Reset values: halted=0, mem_err=0, both counters 0, wait_cnt=0, drain_cnt=0.
- While rst is high, every enable, bubble and flush output is 0.
- Default (RUN, no event): every *_we=1, every bubble/flush=0, pc_sel_branch=0.
- Freeze, highest priority, in RUN/MEM_WAIT/DRAIN:
  - Condition: mem_req && !mem_ready.
  - Response: pc_we=if_id_we=id_ex_we=ex_mem_we=0, mem_wb_bubble=1, all other events ignored this cycle.
  - RUN moves to MEM_WAIT and wait_cnt counts up.
  - MEM_WAIT returns to RUN on the first ready or !mem_req cycle, which behaves as a normal RUN cycle.
  - In DRAIN the state is retained and drain_cnt is paused.
- Timeout: if wait_cnt reaches MEM_TIMEOUT while still frozen, the next state is HALT and mem_err is set.
- Branch flush, second priority, RUN only: ex_branch_taken gives pc_we=1, pc_sel_branch=1, if_id_flush=1, id_ex_bubble=1, and flush_count is incremented.
  - This overrides id_inv_op and load-use in the same cycle.
- Invalid op, third priority, RUN only: id_inv_op gives pc_we=0, if_id_we=0, id_ex_bubble=1, drain_cnt=DRAIN_DEPTH, and the state moves to DRAIN.
- Load-use, fourth priority, RUN only:
  - Condition: ex_memread && ex_rd!=0 && ((ex_rd==id_rs1 && id_use_rs1) || (ex_rd==id_rs2 && id_use_rs2)).
  - Response: pc_we=0, if_id_we=0, id_ex_bubble=1, exactly one cycle per occurrence.
- DRAIN: pc_we=0, if_id_we=0, id_ex_bubble=1, ex_mem_we=1. drain_cnt decrements on each unfrozen cycle; at 0 the state moves to HALT.
- HALT: halted=1 and all *_we=0; rst is the only exit.
- Counters saturate at all-ones.

## Timing
- All enable, bubble and flush outputs are combinational from state and inputs, asserted in the same cycle as the hazard.
- Consumers sample them at the next posedge.
- halted, mem_err and the counters are registered and update at the posedge after the event.
- Load-use costs 1 bubble. A taken branch costs 2 squashed slots (IF/ID and ID/EX).
- id_inv_op gives halted=1 after DRAIN_DEPTH+1 posedges, with no freezes in between.
- A branch held during a freeze is applied on the first unfrozen cycle, because the frozen ID/EX keeps ex_branch_taken asserted.
- rst mid-DRAIN or mid-MEM_WAIT returns to RUN immediately (asynchronous), with counters cleared.

## Test plan
- ex_memread=1, ex_rd=5, id_rs1=5, id_use_rs1=1 for one cycle -> pc_we=0, if_id_we=0, id_ex_bubble=1 that cycle only. stall_cycles increments by 1. With ex_rd=0 instead -> no stall.
- ex_branch_taken=1 together with a load-use match and id_inv_op=1 -> pc_sel_branch=1, if_id_flush=1, id_ex_bubble=1, state stays RUN, flush_count=1.
- mem_req=1 with mem_ready low for 4 cycles then high -> 4 frozen cycles with mem_wb_bubble=1, then full enables. stall_cycles=4, mem_err=0.
- mem_ready held low with MEM_TIMEOUT=8 -> HALT entered after 8 frozen cycles; mem_err=1, halted=1, all enables 0 until rst.
- id_inv_op=1 in RUN, no memory traffic -> 3 DRAIN cycles with ex_mem_we=1 and pc_we=0, then halted=1 at the 4th posedge. Repeat with a 2-cycle freeze inside DRAIN -> halted delayed by exactly 2 cycles.
- Assert rst during MEM_WAIT -> all outputs 0 immediately. After release: state RUN, counters 0, mem_err=0.
